// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
// Mode encodings, HI/LO select values, FSM state type and small mode decoders.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULTU = 2'b00,
        MD_DIVU  = 2'b01,
        MD_MULT  = 2'b10,
        MD_DIV   = 2'b11
    } md_e;

    localparam logic SEL_HIGH = 1'b1;
    localparam logic SEL_LOW  = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_e;

    // Bit 0 of the mode selects divide, bit 1 selects the signed flavour.
    function automatic logic md_is_div(input logic [1:0] md);
        return md[0];
    endfunction

    function automatic logic md_is_signed(input logic [1:0] md);
        return md[1];
    endfunction

endpackage

// File: rtl/muldiv_iter_if.sv
// muldiv_iter_if: pipeline-side bus of the multiply/divide unit.
// The master (execute stage) launches operations and accesses HI/LO;
// the slave (muldiv_iter) reports Busy/Flag/DivZero and the selected HI/LO.
interface muldiv_iter_if #(
    parameter int WIDTH = 32
);
    logic             MUL_Start;
    logic [1:0]       MUL_SelMD;
    logic [WIDTH-1:0] MUL_DA;
    logic [WIDTH-1:0] MUL_DB;
    logic             MUL_SelHL;
    logic             MUL_Write;
    logic             MUL_Cancel;
    logic             MUL_Busy;
    logic             MUL_Flag;
    logic             MUL_DivZero;
    logic [WIDTH-1:0] MUL_DC;

    modport master (
        output MUL_Start, MUL_SelMD, MUL_DA, MUL_DB, MUL_SelHL, MUL_Write, MUL_Cancel,
        input  MUL_Busy, MUL_Flag, MUL_DivZero, MUL_DC
    );

    modport slave (
        input  MUL_Start, MUL_SelMD, MUL_DA, MUL_DB, MUL_SelHL, MUL_Write, MUL_Cancel,
        output MUL_Busy, MUL_Flag, MUL_DivZero, MUL_DC
    );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration on the {hi,lo} accumulator.
// Multiply: add-or-pass of the multiplicand into hi, then shift the pair right.
// Divide: shift the pair left, trial-subtract the divisor from the partial
// remainder and shift the quotient bit into lo (restoring).
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   rem_sh_s;
    logic             ge_s;
    logic [WIDTH-1:0] diff_s;

    // Single combinational iteration for both operation kinds.
    always_comb begin
        sum_s    = {1'b0, hi_i} + {1'b0, opnd_i};
        rem_sh_s = {hi_i, lo_i[WIDTH-1]};
        // The partial remainder stays below the divisor, so a set top bit
        // after the shift already guarantees the subtraction succeeds and
        // the true difference always fits in WIDTH bits.
        ge_s     = rem_sh_s[WIDTH] | (rem_sh_s[WIDTH-1:0] >= opnd_i);
        diff_s   = rem_sh_s[WIDTH-1:0] - opnd_i;
        hi_o     = hi_i;
        lo_o     = lo_i;
        if (is_div_i) begin
            if (ge_s) begin
                hi_o = diff_s;
                lo_o = {lo_i[WIDTH-2:0], 1'b1};
            end else begin
                hi_o = rem_sh_s[WIDTH-1:0];
                lo_o = {lo_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (lo_i[0]) begin
                {hi_o, lo_o} = {sum_s, lo_i[WIDTH-1:1]};
            end else begin
                {hi_o, lo_o} = {1'b0, hi_i, lo_i[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative multiply/divide unit owning the HI/LO pair.
// IDLE -> RUN (WIDTH radix-2 steps) -> FIX (sign fix, HI/LO write, Flag).
// Optional macro MULDIV_SIGNED_EN enables signed MULT/DIV in modes 10/11;
// without it those modes run unsigned with identical latency.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         Clk,
    input  logic         Reset,
    muldiv_iter_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] da_q, da_d;
    logic             is_div_q, is_div_d;
    logic             dz_op_q, dz_op_d;
    logic             flag_q, flag_d;
    logic             divzero_q, divzero_d;
    logic             busy_q, busy_d;
`ifdef MULDIV_SIGNED_EN
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             a_neg_s, b_neg_s;
`endif

    logic [WIDTH-1:0] mag_a_s, mag_b_s;
    logic [WIDTH-1:0] step_hi_s, step_lo_s;
    logic [WIDTH-1:0] corr_hi_s, corr_lo_s;
    logic [WIDTH-1:0] res_hi_s, res_lo_s;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div_i (is_div_q),
        .hi_i     (acc_hi_q),
        .lo_i     (acc_lo_q),
        .opnd_i   (opnd_q),
        .hi_o     (step_hi_s),
        .lo_o     (step_lo_s)
    );

    // Operand magnitudes (and sign bits in signed modes) seen at launch.
    always_comb begin
`ifdef MULDIV_SIGNED_EN
        a_neg_s = md_is_signed(bus.MUL_SelMD) & bus.MUL_DA[WIDTH-1];
        b_neg_s = md_is_signed(bus.MUL_SelMD) & bus.MUL_DB[WIDTH-1];
        if (a_neg_s) begin
            mag_a_s = {WIDTH{1'b0}} - bus.MUL_DA;
        end else begin
            mag_a_s = bus.MUL_DA;
        end
        if (b_neg_s) begin
            mag_b_s = {WIDTH{1'b0}} - bus.MUL_DB;
        end else begin
            mag_b_s = bus.MUL_DB;
        end
`else
        mag_a_s = bus.MUL_DA;
        mag_b_s = bus.MUL_DB;
`endif
    end

    // Final HI/LO value: sign correction, then the divide-by-zero override.
    always_comb begin
        corr_hi_s = acc_hi_q;
        corr_lo_s = acc_lo_q;
`ifdef MULDIV_SIGNED_EN
        if (is_div_q) begin
            if (neg_lo_q) begin
                corr_lo_s = {WIDTH{1'b0}} - acc_lo_q;
            end else begin
                corr_lo_s = acc_lo_q;
            end
            if (neg_hi_q) begin
                corr_hi_s = {WIDTH{1'b0}} - acc_hi_q;
            end else begin
                corr_hi_s = acc_hi_q;
            end
        end else begin
            if (neg_lo_q) begin
                {corr_hi_s, corr_lo_s} = {(2*WIDTH){1'b0}} - {acc_hi_q, acc_lo_q};
            end else begin
                {corr_hi_s, corr_lo_s} = {acc_hi_q, acc_lo_q};
            end
        end
`endif
        // MIN / -1 needs no special case: |MIN| / 1 leaves the quotient at
        // MIN with a positive sign and the remainder at zero.
        if (is_div_q && dz_op_q) begin
            res_lo_s = {WIDTH{1'b1}};
            res_hi_s = da_q;
        end else begin
            res_lo_s = corr_lo_s;
            res_hi_s = corr_hi_s;
        end
    end

    // FSM next state, operand capture, iteration and HI/LO update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opnd_d    = opnd_q;
        da_d      = da_q;
        is_div_d  = is_div_q;
        dz_op_d   = dz_op_q;
        flag_d    = 1'b0;
        divzero_d = 1'b0;
`ifdef MULDIV_SIGNED_EN
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
`endif
        case (state_q)
            IDLE: begin
                // MTHI/MTLO is only honoured here; it may share the cycle
                // with a launch, and the result overwrites it later.
                if (bus.MUL_Write) begin
                    if (bus.MUL_SelHL == SEL_HIGH) begin
                        hi_d = bus.MUL_DB;
                    end else begin
                        lo_d = bus.MUL_DB;
                    end
                end else begin
                    hi_d = hi_q;
                    lo_d = lo_q;
                end
                if (bus.MUL_Start && !bus.MUL_Cancel) begin
                    state_d  = RUN;
                    cnt_d    = {CNT_W{1'b0}};
                    is_div_d = md_is_div(bus.MUL_SelMD);
                    da_d     = bus.MUL_DA;
                    dz_op_d  = (bus.MUL_DB == {WIDTH{1'b0}});
                    acc_hi_d = {WIDTH{1'b0}};
                    if (md_is_div(bus.MUL_SelMD)) begin
                        opnd_d   = mag_b_s;
                        acc_lo_d = mag_a_s;
                    end else begin
                        opnd_d   = mag_a_s;
                        acc_lo_d = mag_b_s;
                    end
`ifdef MULDIV_SIGNED_EN
                    neg_lo_d = a_neg_s ^ b_neg_s;
                    if (md_is_div(bus.MUL_SelMD)) begin
                        neg_hi_d = a_neg_s;
                    end else begin
                        neg_hi_d = a_neg_s ^ b_neg_s;
                    end
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (bus.MUL_Cancel) begin
                    state_d = IDLE;
                end else begin
                    acc_hi_d = step_hi_s;
                    acc_lo_d = step_lo_s;
                    cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = FIX;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            FIX: begin
                if (bus.MUL_Cancel) begin
                    state_d = IDLE;
                end else begin
                    hi_d      = res_hi_s;
                    lo_d      = res_lo_s;
                    flag_d    = 1'b1;
                    divzero_d = is_div_q & dz_op_q;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            acc_hi_q  <= {WIDTH{1'b0}};
            acc_lo_q  <= {WIDTH{1'b0}};
            opnd_q    <= {WIDTH{1'b0}};
            da_q      <= {WIDTH{1'b0}};
            is_div_q  <= 1'b0;
            dz_op_q   <= 1'b0;
            flag_q    <= 1'b0;
            divzero_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opnd_q    <= opnd_d;
            da_q      <= da_d;
            is_div_q  <= is_div_d;
            dz_op_q   <= dz_op_d;
            flag_q    <= flag_d;
            divzero_q <= divzero_d;
            busy_q    <= busy_d;
`ifdef MULDIV_SIGNED_EN
            neg_lo_q  <= neg_lo_d;
            neg_hi_q  <= neg_hi_d;
`endif
        end
    end

    assign bus.MUL_Busy    = busy_q;
    assign bus.MUL_Flag    = flag_q;
    assign bus.MUL_DivZero = divzero_q;
    assign bus.MUL_DC      = (bus.MUL_SelHL == SEL_HIGH) ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: directed self-checking bench for muldiv_iter (WIDTH = 32).
// Signed-mode expectations follow MULDIV_SIGNED_EN.
module tb_muldiv_iter;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   errs   = 0;
    int   checks = 0;

    muldiv_iter_if #(.WIDTH(32)) bus ();

    muldiv_iter #(.WIDTH(32)) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic read_hl(output logic [31:0] hi, output logic [31:0] lo);
        bus.MUL_SelHL = SEL_HIGH;
        #1;
        hi = bus.MUL_DC;
        bus.MUL_SelHL = SEL_LOW;
        #1;
        lo = bus.MUL_DC;
    endtask

    // Launch one operation and wait (bounded) until Busy drops; returns in
    // the cycle where Flag should be high.
    task automatic do_op(input logic [1:0] md, input logic [31:0] a, input logic [31:0] b,
                         output int n, output int early, output logic fe, output logic dz);
        bus.MUL_SelMD = md;
        bus.MUL_DA    = a;
        bus.MUL_DB    = b;
        bus.MUL_Start = 1'b1;
        tick;
        bus.MUL_Start = 1'b0;
        n     = 0;
        early = 0;
        while (bus.MUL_Busy === 1'b1 && n < 100) begin
            n++;
            if (bus.MUL_Flag === 1'b1) early++;
            tick;
        end
        fe = bus.MUL_Flag;
        dz = bus.MUL_DivZero;
    endtask

    task automatic check_op(input string tag, input logic [1:0] md, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_hi,
                            input logic [31:0] exp_lo, input logic exp_dz);
        int          n, early;
        logic        fe, dz;
        logic [31:0] hi, lo;
        do_op(md, a, b, n, early, fe, dz);
        read_hl(hi, lo);
        check({tag, " busy_cycles"}, 32'(n), 32'd33);
        check({tag, " flag_while_busy"}, 32'(early), 32'd0);
        check({tag, " flag"}, {31'd0, fe}, 32'd1);
        check({tag, " divzero"}, {31'd0, dz}, {31'd0, exp_dz});
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
        tick;
        check({tag, " flag_drop"}, {31'd0, bus.MUL_Flag}, 32'd0);
        check({tag, " divzero_drop"}, {31'd0, bus.MUL_DivZero}, 32'd0);
    endtask

    initial begin
        int          n, early, nflag;
        logic        fe, dz;
        logic [31:0] hi, lo;

        reset          = 1'b1;
        bus.MUL_Start  = 1'b0;
        bus.MUL_SelMD  = 2'b00;
        bus.MUL_DA     = 32'd0;
        bus.MUL_DB     = 32'd0;
        bus.MUL_SelHL  = SEL_LOW;
        bus.MUL_Write  = 1'b0;
        bus.MUL_Cancel = 1'b0;
        tick;
        tick;
        reset = 1'b0;

        // Reset state
        read_hl(hi, lo);
        check("rst busy", {31'd0, bus.MUL_Busy}, 32'd0);
        check("rst flag", {31'd0, bus.MUL_Flag}, 32'd0);
        check("rst divzero", {31'd0, bus.MUL_DivZero}, 32'd0);
        check("rst hi", hi, 32'd0);
        check("rst lo", lo, 32'd0);

        // Main function
        check_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        check_op("divu_100_7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
`ifdef MULDIV_SIGNED_EN
        check_op("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        check_op("mult_m3_5", MD_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        check_op("div_min_m1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        check_op("div_m7_0", MD_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
`else
        check_op("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
        check_op("mult_m3_5", MD_MULT, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1, 1'b0);
        check_op("div_min_m1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0);
        check_op("div_m7_0", MD_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
`endif
        check_op("divu_5_0", MD_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);

        // Back-to-back: second Start in the cycle Flag is high
        do_op(MD_DIVU, 32'd100, 32'd7, n, early, fe, dz);
        check("b2b first flag", {31'd0, fe}, 32'd1);
        check_op("b2b_multu_6_7", MD_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

        // MTHI / MTLO while idle
        bus.MUL_Write = 1'b1;
        bus.MUL_SelHL = SEL_HIGH;
        bus.MUL_DB    = 32'h0000_1234;
        tick;
        bus.MUL_SelHL = SEL_LOW;
        bus.MUL_DB    = 32'h0000_ABCD;
        tick;
        bus.MUL_Write = 1'b0;
        read_hl(hi, lo);
        check("write hi", hi, 32'h0000_1234);
        check("write lo", lo, 32'h0000_ABCD);

        // Start, ignored Start + Write at cycle 5, Cancel at cycle 10
        bus.MUL_SelMD = MD_DIVU;
        bus.MUL_DA    = 32'd100;
        bus.MUL_DB    = 32'd7;
        bus.MUL_Start = 1'b1;
        tick;
        bus.MUL_Start = 1'b0;
        repeat (4) tick;
        bus.MUL_Start = 1'b1;
        bus.MUL_SelMD = MD_MULTU;
        bus.MUL_DB    = 32'h0000_5555;
        bus.MUL_Write = 1'b1;
        bus.MUL_SelHL = SEL_HIGH;
        tick;
        bus.MUL_Start = 1'b0;
        bus.MUL_Write = 1'b0;
        check("busy midop", {31'd0, bus.MUL_Busy}, 32'd1);
        read_hl(hi, lo);
        check("dc during busy hi", hi, 32'h0000_1234);
        repeat (4) tick;
        bus.MUL_Cancel = 1'b1;
        tick;
        bus.MUL_Cancel = 1'b0;
        check("cancel busy", {31'd0, bus.MUL_Busy}, 32'd0);
        nflag = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.MUL_Flag === 1'b1) nflag++;
            tick;
        end
        check("cancel no flag", 32'(nflag), 32'd0);
        read_hl(hi, lo);
        check("cancel hi kept", hi, 32'h0000_1234);
        check("cancel lo kept", lo, 32'h0000_ABCD);

        // Write and Start in the same idle cycle
        bus.MUL_SelMD = MD_MULTU;
        bus.MUL_DA    = 32'd3;
        bus.MUL_DB    = 32'd4;
        bus.MUL_Start = 1'b1;
        bus.MUL_Write = 1'b1;
        bus.MUL_SelHL = SEL_LOW;
        tick;
        bus.MUL_Start = 1'b0;
        bus.MUL_Write = 1'b0;
        read_hl(hi, lo);
        check("wr+start lo now", lo, 32'd4);
        n = 0;
        while (bus.MUL_Busy === 1'b1 && n < 100) begin
            n++;
            tick;
        end
        check("wr+start busy_cycles", 32'(n), 32'd33);
        check("wr+start flag", {31'd0, bus.MUL_Flag}, 32'd1);
        read_hl(hi, lo);
        check("wr+start hi", hi, 32'd0);
        check("wr+start lo", lo, 32'd12);
        tick;

        // Reset at cycle 12 of an operation
        bus.MUL_SelMD = MD_MULTU;
        bus.MUL_DA    = 32'hFFFF_FFFF;
        bus.MUL_DB    = 32'hFFFF_FFFF;
        bus.MUL_Start = 1'b1;
        tick;
        bus.MUL_Start = 1'b0;
        repeat (11) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        read_hl(hi, lo);
        check("midrst busy", {31'd0, bus.MUL_Busy}, 32'd0);
        check("midrst flag", {31'd0, bus.MUL_Flag}, 32'd0);
        check("midrst hi", hi, 32'd0);
        check("midrst lo", lo, 32'd0);
        nflag = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.MUL_Flag === 1'b1) nflag++;
            tick;
        end
        check("midrst no flag", 32'(nflag), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
